// File: rtl/seg_scan_ctrl.sv
// Scan controller for an NDIG-digit common-anode 7-segment display.
// It shares one external decoder across all digits, double-buffers frame updates, and blanks between digits.
module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 50000,
    parameter int BLANK = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [4*NDIG-1:0]    wr_data,
    input  logic [NDIG-1:0]      wr_off,
    output logic [3:0]           dec_b,
    input  logic [6:0]           dec_h,
    output logic [6:0]           seg,
    output logic [NDIG-1:0]      an,
    output logic                 frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [4*NDIG-1:0]   act_code, pend_code;
    logic [NDIG-1:0]     act_off, pend_off;
    logic                pend_valid;
    logic                slot_end, boundary;
    logic [6:0]          seg_nxt;
    logic [NDIG-1:0]     an_nxt;

    assign wr_ready = ~pend_valid;
    assign dec_b    = act_code[{idx, 2'b00} +: 4];

    // The outputs are computed from the next slot position, so the blanking window lines up with the registered outputs.
    always_comb begin
        slot_end  = (cnt == CNT_MAX);
        boundary  = slot_end && (idx == IDX_MAX);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        idx_nxt   = idx;
        if (slot_end) begin
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
        state_nxt = state;
        case (state)
            S_BLANK: if (cnt_nxt == BLANK_C) state_nxt = S_DRIVE;
            S_DRIVE: if (slot_end) state_nxt = S_BLANK;
            default: state_nxt = S_BLANK;
        endcase
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        if (state_nxt == S_DRIVE && !act_off[idx]) begin
            an_nxt  = ~(NDIG'(1) << idx);
            seg_nxt = dec_h;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BLANK;
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
            act_code   <= '0;
            act_off    <= '1;
            pend_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
            if (boundary && pend_valid) begin
                act_code   <= pend_code;
                act_off    <= pend_off;
                pend_valid <= 1'b0;
            end else if (wr_valid && !pend_valid) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Pending payload is plain data; pend_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready) begin
            pend_code <= wr_data;
            pend_off  <= wr_off;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a frame-level reference model with a per-cycle compare, plus directed literal checks.
module tb_seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [4*NDIG-1:0] wr_data = '0;
    logic [NDIG-1:0]   wr_off = '0;
    logic [3:0]        dec_b;
    logic [6:0]        dec_h;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic              frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_seen = 0;
    int fd0 = 0;

    // Reference model state
    int              k;
    logic [3:0]      m_code [NDIG];
    logic [NDIG-1:0] m_off;
    logic [3:0]      p_code [NDIG];
    logic [NDIG-1:0] p_off;
    logic            m_pend;

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    assign dec_h = seg7(dec_b);

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_off(wr_off), .dec_b(dec_b), .dec_h(dec_h),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, k);
        end
    endtask

    // k counts clock edges since reset release; frame commits land on multiples of FRAME.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= 0;
            m_off  <= '1;
            m_pend <= 1'b0;
            for (int i = 0; i < NDIG; i++) m_code[i] <= '0;
        end else begin
            k <= k + 1;
            if ((k + 1) % FRAME == 0 && m_pend) begin
                for (int i = 0; i < NDIG; i++) m_code[i] <= p_code[i];
                m_off  <= p_off;
                m_pend <= 1'b0;
            end else if (wr_valid && !m_pend) begin
                for (int i = 0; i < NDIG; i++) p_code[i] <= wr_data[4*i +: 4];
                p_off  <= wr_off;
                m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int c;
        int d;
        logic blank;
        logic [NDIG-1:0] ea;
        if (rst_n) begin
            c     = k % DIV;
            d     = (k / DIV) % NDIG;
            blank = (c < BLANK) || m_off[d];
            ea    = blank ? '1 : ~(NDIG'(1) << d);
            chk("an", an, ea);
            chk("seg", seg, blank ? 7'h7F : seg7(m_code[d]));
            chk("frame_done", frame_done, (k != 0) && (k % FRAME == 0));
            chk("wr_ready", wr_ready, !m_pend);
            chk("dec_b", dec_b, m_code[d]);
            if (frame_done) fd_seen++;
        end
    end

    task automatic go(input int t);
        while (k < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [NDIG-1:0] an_l  [4];
        logic [6:0]      seg_l [4];
        an_l  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_l = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};

        #12;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_ready", wr_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: dark display, frame_done at 32 and 64
        go(31); chk("idle_fd31", frame_done, 1'b0);
        go(32); chk("idle_fd32", frame_done, 1'b1);
        go(64); chk("idle_fd64", frame_done, 1'b1);
        chk("idle_ready", wr_ready, 1'b1);
        chk("idle_an", an, 4'hF);

        // Single mid-frame write
        go(69); wr_valid = 1'b1; wr_data = 16'h3210; wr_off = 4'h0;
        go(70); wr_valid = 1'b0; chk("s2_ready_drop", wr_ready, 1'b0);
        go(96); chk("s2_fd", frame_done, 1'b1); chk("s2_ready_back", wr_ready, 1'b1);
        for (int s = 0; s < 4; s++) begin
            go(96 + 8*s + 1);
            chk("s2_blank_an", an, 4'hF);
            chk("s2_blank_seg", seg, 7'h7F);
            go(96 + 8*s + 4);
            chk("s2_drive_an", an, an_l[s]);
            chk("s2_drive_seg", seg, seg_l[s]);
        end

        // Two writes in one frame: second stalls until the commit
        go(129); wr_valid = 1'b1; wr_data = 16'h4567;
        go(130); wr_data = 16'h89AB; chk("s3_stall", wr_ready, 1'b0);
        go(159); chk("s3_stall_end", wr_ready, 1'b0);
        go(160); chk("s3_ready_commit", wr_ready, 1'b1);
        go(161); wr_valid = 1'b0; chk("s3_second_acc", wr_ready, 1'b0);
        go(170); chk("s3_first_an", an, 4'hD); chk("s3_first_seg", seg, 7'b0100000);
        go(196); chk("s3_second_an", an, 4'hE); chk("s3_second_seg", seg, 7'b1100000);

        // Write on the boundary cycle, with an off mask on digit 2
        go(223); wr_valid = 1'b1; wr_data = 16'h3210; wr_off = 4'b0100;
        go(224); wr_valid = 1'b0; chk("s4_acc", wr_ready, 1'b0);
        go(225); fd0 = fd_seen;
        go(228); chk("s4_old_an", an, 4'hE); chk("s4_old_seg", seg, 7'b1100000);
        go(257); chk("s4_one_fd", fd_seen - fd0, 1);
        for (int s = 0; s < 4; s++) begin
            go(256 + 8*s + 4);
            chk("s5_an", an, (s == 2) ? 4'hF : an_l[s]);
            chk("s5_seg", seg, (s == 2) ? 7'h7F : seg_l[s]);
        end

        // Reset during slot 2 drive with a write pending
        go(289); wr_valid = 1'b1; wr_data = 16'h7654; wr_off = 4'h0;
        go(290); wr_valid = 1'b0;
        go(320); wr_valid = 1'b1; wr_data = 16'h9999;
        go(321); wr_valid = 1'b0; chk("s6_pending", wr_ready, 1'b0);
        go(340); chk("s6_pre_an", an, 4'hB); chk("s6_pre_seg", seg, 7'b0100000);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_async_an", an, 4'hF);
        chk("s6_async_seg", seg, 7'h7F);
        chk("s6_async_fd", frame_done, 1'b0);
        chk("s6_async_ready", wr_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        go(4); chk("s6_dark_an", an, 4'hF); chk("s6_decb", dec_b, 4'h0);
        go(31); chk("s6_fd31", frame_done, 1'b0);
        go(32); chk("s6_fd32", frame_done, 1'b1);
        go(70); chk("s6_never_an", an, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
